sevenseg_port_display: RTL and testbench

SEVENSEG_PORT_DISPLAY -- requirements
Module: sevenseg_port_display

---
 rtl/sevenseg_port_display.sv | 218 +++++++++++++++++++++
 tb/tb_sevenseg_port_display.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sevenseg_port_display.sv
// Shows three 32-bit I/O output ports as 2-digit decimal numbers on a
// 6-digit multiplexed, active-low seven-segment display.
module sevenseg_port_display #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        io_clk,
  input  logic        resetn,
  input  logic [31:0] out_port0,
  input  logic [31:0] out_port1,
  input  logic [31:0] out_port2,
  output logic [5:0]  digit_an,
  output logic [6:0]  seg,
  output logic        conv_busy
);

  localparam int unsigned   PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    CAPTURE,
    SHIFT,
    COMMIT
  } conv_state_e;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------
  // Binary-to-BCD converter, round-robin over the three ports
  // ---------------------------------------------------------------
  conv_state_e state_q, state_d;
  logic [1:0]  p_q, p_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  sh_q, sh_d;
  logic [7:0]  bcd_q, bcd_d;
  logic        ovf_tmp_q, ovf_tmp_d;
  logic [31:0] port_sel;
  logic [7:0]  bcd_adj;
  logic        commit;

  always_comb begin
    case (p_q)
      2'd0:    port_sel = out_port0;
      2'd1:    port_sel = out_port1;
      2'd2:    port_sel = out_port2;
      default: port_sel = '0;
    endcase
  end

  always_comb begin
    bcd_adj[3:0] = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    bcd_adj[7:4] = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
  end

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    bcd_d     = bcd_q;
    ovf_tmp_d = ovf_tmp_q;
    commit    = 1'b0;
    case (state_q)
      CAPTURE: begin
        sh_d      = port_sel[6:0];
        bcd_d     = '0;
        ovf_tmp_d = (port_sel > 32'd99);
        cnt_d     = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        // seven adjust-and-shift steps, the eighth cycle only holds
        if (cnt_q != 3'd7) begin
          bcd_d = {bcd_adj[6:0], sh_q[6]};
          sh_d  = {sh_q[5:0], 1'b0};
        end else begin
          state_d = COMMIT;
        end
        cnt_d = cnt_q + 3'd1;
      end
      COMMIT: begin
        commit  = 1'b1;
        p_d     = (p_q == 2'd2) ? 2'd0 : p_q + 2'd1;
        state_d = CAPTURE;
      end
      default: state_d = CAPTURE;
    endcase
  end

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= CAPTURE;
      p_q       <= '0;
      cnt_q     <= '0;
      sh_q      <= '0;
      bcd_q     <= '0;
      ovf_tmp_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      bcd_q     <= bcd_d;
      ovf_tmp_q <= ovf_tmp_d;
    end
  end

  assign conv_busy = (state_q == SHIFT);

  // ---------------------------------------------------------------
  // Display registers, written only on COMMIT
  // ---------------------------------------------------------------
  logic [3:0] tens_q [0:2];
  logic [3:0] ones_q [0:2];
  logic [2:0] ovf_q;

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < 3; i++) begin
        tens_q[i] <= '0;
        ones_q[i] <= '0;
      end
      ovf_q <= '0;
    end else if (commit) begin
      case (p_q)
        2'd0: begin
          tens_q[0] <= bcd_q[7:4];
          ones_q[0] <= bcd_q[3:0];
          ovf_q[0]  <= ovf_tmp_q;
        end
        2'd1: begin
          tens_q[1] <= bcd_q[7:4];
          ones_q[1] <= bcd_q[3:0];
          ovf_q[1]  <= ovf_tmp_q;
        end
        2'd2: begin
          tens_q[2] <= bcd_q[7:4];
          ones_q[2] <= bcd_q[3:0];
          ovf_q[2]  <= ovf_tmp_q;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Digit scanner
  // ---------------------------------------------------------------
  logic [PW-1:0] presc_q;
  logic [2:0]    idx_q;
  logic [3:0]    dig_val;
  logic          dig_tens;
  logic          dig_ovf;
  logic [6:0]    seg_d;
  logic [5:0]    an_d;

  always_comb begin
    dig_val  = '0;
    dig_tens = 1'b0;
    dig_ovf  = 1'b0;
    case (idx_q)
      3'd0: begin dig_val = ones_q[0]; dig_ovf = ovf_q[0]; end
      3'd1: begin dig_val = tens_q[0]; dig_ovf = ovf_q[0]; dig_tens = 1'b1; end
      3'd2: begin dig_val = ones_q[1]; dig_ovf = ovf_q[1]; end
      3'd3: begin dig_val = tens_q[1]; dig_ovf = ovf_q[1]; dig_tens = 1'b1; end
      3'd4: begin dig_val = ones_q[2]; dig_ovf = ovf_q[2]; end
      3'd5: begin dig_val = tens_q[2]; dig_ovf = ovf_q[2]; dig_tens = 1'b1; end
      default: ;
    endcase

    if (dig_ovf)
      seg_d = SEG_DASH;
    else if (dig_tens && dig_val == 4'd0)
      seg_d = SEG_BLANK;
    else
      seg_d = seg_decode(dig_val);

    an_d = ~(6'd1 << idx_q);
  end

  // anode and segments load together from the same idx, so no glitch
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      presc_q  <= '0;
      idx_q    <= '0;
      digit_an <= '1;
      seg      <= '1;
    end else begin
      if (presc_q == PRESC_LAST) begin
        presc_q <= '0;
        idx_q   <= (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
      digit_an <= an_d;
      seg      <= seg_d;
    end
  end

endmodule

// File: tb/tb_sevenseg_port_display.sv
// Directed bench for sevenseg_port_display with SCAN_DIV=4; expected
// segment patterns are hand-computed constants.
module tb_sevenseg_port_display;

  logic        io_clk = 1'b0;
  logic        resetn;
  logic [31:0] out_port0;
  logic [31:0] out_port1;
  logic [31:0] out_port2;
  logic [5:0]  digit_an;
  logic [6:0]  seg;
  logic        conv_busy;

  int checks     = 0;
  int errors     = 0;
  int ecount     = 0;
  int onehot_bad = 0;

  always #5 io_clk = ~io_clk;

  sevenseg_port_display #(.SCAN_DIV(4)) dut (
    .io_clk    (io_clk),
    .resetn    (resetn),
    .out_port0 (out_port0),
    .out_port1 (out_port1),
    .out_port2 (out_port2),
    .digit_an  (digit_an),
    .seg       (seg),
    .conv_busy (conv_busy)
  );

  always @(negedge io_clk)
    if ($countones(digit_an) < 5) onehot_bad++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the negedge following rising edge 'target' since release.
  task automatic step_to(input int target);
    while (ecount < target) begin
      @(negedge io_clk);
      ecount++;
    end
  endtask

  task automatic do_reset(input int n);
    resetn = 1'b0;
    repeat (n) @(negedge io_clk);
    check("rst_an", {26'd0, digit_an}, 32'h3f);
    check("rst_seg", {25'd0, seg}, 32'h7f);
    check("rst_busy", {31'd0, conv_busy}, 32'd0);
    resetn = 1'b1;
    ecount = 0;
  endtask

  task automatic check_digit(input string tag, input int d, input logic [6:0] exp);
    logic [5:0] want;
    int guard;
    want  = ~(6'd1 << d);
    guard = 0;
    while (digit_an !== want && guard < 40) begin
      step_to(ecount + 1);
      guard++;
    end
    check({tag, "_window"}, {26'd0, digit_an}, {26'd0, want});
    check(tag, {25'd0, seg}, {25'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] want_an;
    resetn    = 1'b0;
    out_port0 = 32'd37;
    out_port1 = 32'd5;
    out_port2 = 32'd99;
    @(negedge io_clk);

    // reset and first edge after release
    do_reset(3);
    check("busy_pre_edge1", {31'd0, conv_busy}, 32'd0);
    step_to(1);
    check("first_an", {26'd0, digit_an}, {26'd0, 6'b111110});
    check("first_seg", {25'd0, seg}, {25'd0, 7'b1000000});
    step_to(2);
    check("busy_edge2", {31'd0, conv_busy}, 32'd1);

    // ports 37, 5, 99 all converted after 30 cycles
    step_to(31);
    check_digit("p0_ones_7", 0, 7'b1111000);
    check_digit("p0_tens_3", 1, 7'b0110000);
    check_digit("p1_ones_5", 2, 7'b0010010);
    check_digit("p1_tens_blank", 3, 7'b1111111);
    check_digit("p2_ones_9", 4, 7'b0010000);
    check_digit("p2_tens_9", 5, 7'b0010000);

    // anode sequence, idx moves every 4 edges
    step_to(80);
    for (int e = 81; e <= 108; e++) begin
      step_to(e);
      want_an = ~(6'd1 << (((e - 1) / 4) % 6));
      check("scan_an", {26'd0, digit_an}, {26'd0, want_an});
    end

    // overflow, zero and ten on port1
    out_port1 = 32'd100;
    step_to(ecount + 40);
    check_digit("p1_100_ones_dash", 2, 7'b0111111);
    check_digit("p1_100_tens_dash", 3, 7'b0111111);
    out_port1 = 32'hFFFF_FFFF;
    step_to(ecount + 40);
    check_digit("p1_max_ones_dash", 2, 7'b0111111);
    check_digit("p1_max_tens_dash", 3, 7'b0111111);
    out_port1 = 32'd0;
    step_to(ecount + 40);
    check_digit("p1_0_ones", 2, 7'b1000000);
    check_digit("p1_0_tens_blank", 3, 7'b1111111);
    out_port1 = 32'd10;
    step_to(ecount + 40);
    check_digit("p1_10_ones", 2, 7'b1000000);
    check_digit("p1_10_tens", 3, 7'b1111001);
    check_digit("p2_tens_kept", 5, 7'b0010000);

    // input change after CAPTURE is held off until next conversion
    out_port0 = 32'd12;
    do_reset(3);
    step_to(1);
    out_port0 = 32'd34;
    step_to(11);
    check_digit("hold_p0_ones_2", 0, 7'b0100100);
    check_digit("hold_p0_tens_1", 1, 7'b1111001);
    step_to(41);
    check_digit("new_p0_ones_4", 0, 7'b0011001);
    check_digit("new_p0_tens_3", 1, 7'b0110000);

    // reset during port1 SHIFT
    out_port0 = 32'd45;
    out_port1 = 32'd67;
    out_port2 = 32'd0;
    do_reset(2);
    step_to(15);
    check("busy_mid_shift", {31'd0, conv_busy}, 32'd1);
    do_reset(2);
    check("busy_after_release", {31'd0, conv_busy}, 32'd0);
    step_to(2);
    check("busy_restart", {31'd0, conv_busy}, 32'd1);
    step_to(12);
    check("abort_p1_ones_an", {26'd0, digit_an}, {26'd0, 6'b111011});
    check("abort_p1_ones_seg", {25'd0, seg}, {25'd0, 7'b1000000});
    step_to(14);
    check("abort_p1_tens_an", {26'd0, digit_an}, {26'd0, 6'b110111});
    check("abort_p1_tens_seg", {25'd0, seg}, {25'd0, 7'b1111111});
    step_to(26);
    check("restart_p0_an", {26'd0, digit_an}, {26'd0, 6'b111110});
    check("restart_p0_seg", {25'd0, seg}, {25'd0, 7'b0010010});
    step_to(38);
    check("later_p1_an", {26'd0, digit_an}, {26'd0, 6'b110111});
    check("later_p1_seg", {25'd0, seg}, {25'd0, 7'b0000010});

    check("anode_onehot", onehot_bad, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
